// File: rtl/ocram_wbuf_bridge_pkg.sv
// ocram_wbuf_bridge_pkg: shared definitions for the on-chip RAM write-buffer bridge.
// Write-buffer entry layout is {addr, byteenable, data} with data at the LSB end.
package ocram_wbuf_bridge_pkg;

    // Which requester owns the RAM port this cycle
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_DRAIN = 2'd2
    } grant_t;

    localparam int ENT_DATA_LSB = 0;

    function automatic int ent_be_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int ent_addr_lsb(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int ent_width(input int addr_w, input int data_w);
        return addr_w + data_w + data_w / 8;
    endfunction

    // Index bits plus one wrap bit so full and empty are distinguishable
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ocram_wbuf_bridge_fifo.sv
// ocram_wbuf_bridge_fifo: register-array write buffer. Besides the head entry it
// exposes a valid flag and the address of every slot so the top can detect
// read-after-write hazards against all queued writes at once.
module ocram_wbuf_bridge_fifo
    import ocram_wbuf_bridge_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int ENT_W = ent_width(ADDR_W, DATA_W)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [ENT_W-1:0]        push_entry,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [ENT_W-1:0]        head_entry,
    output logic [DEPTH-1:0]        ent_valid,
    output logic [DEPTH*ADDR_W-1:0] ent_addr
);
    localparam int PTR_W    = ptr_width(DEPTH);
    localparam int IDX_W    = PTR_W - 1;
    localparam int ADDR_LSB = ent_addr_lsb(DATA_W);

    logic [ENT_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] count;

    assign count      = wr_ptr_reg - rd_ptr_reg;
    assign empty      = (wr_ptr_reg == rd_ptr_reg);
    assign full       = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                        (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
    assign head_entry = mem_reg[rd_ptr_reg[IDX_W-1:0]];

    // Pointer advance; queued entries are discarded on reset by equalising pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    // Entry storage; contents are only meaningful while the slot is valid
    always_ff @(posedge clk) begin
        if (push) mem_reg[wr_ptr_reg[IDX_W-1:0]] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below the fill count
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
        logic [IDX_W-1:0] offset;
        assign offset = IDX_W'(gi) - rd_ptr_reg[IDX_W-1:0];
        assign ent_valid[gi] = ({1'b0, offset} < count);
        assign ent_addr[gi*ADDR_W +: ADDR_W] = mem_reg[gi][ADDR_LSB +: ADDR_W];
    end

endmodule

// File: rtl/ocram_wbuf_bridge.sv
// ocram_wbuf_bridge: Avalon-MM slave front-end for a single-port on-chip RAM with
// 1-cycle read latency. Writes are posted into a small FIFO and drained when the
// RAM port is free; reads bypass queued writes unless they hit a queued address.
// Define OCRAM_WBUF_STATS_EN to build the read/write/hazard-stall counters; without
// it the stat outputs read 0 and stats_clr is ignored.
module ocram_wbuf_bridge
    import ocram_wbuf_bridge_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W/8-1:0] s_byteenable,
    input  logic [DATA_W-1:0]   s_writedata,
    output logic                s_waitrequest,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata,
    input  logic                stats_clr,
    output logic [31:0]         stat_reads,
    output logic [31:0]         stat_writes,
    output logic [31:0]         stat_hazard_stalls
);
    localparam int BE_W     = DATA_W / 8;
    localparam int ENT_W    = ent_width(ADDR_W, DATA_W);
    localparam int BE_LSB   = ent_be_lsb(DATA_W);
    localparam int ADDR_LSB = ent_addr_lsb(DATA_W);

    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_pop;
    logic [ENT_W-1:0]             push_entry;
    logic [ENT_W-1:0]             head_entry;
    logic [WBUF_DEPTH-1:0]        ent_valid;
    logic [WBUF_DEPTH-1:0]        addr_match;
    logic [WBUF_DEPTH*ADDR_W-1:0] ent_addr;
    logic                         hazard;
    logic                         rd_acc;
    logic                         wr_acc;
    logic                         ready_reg;
    logic                         rdv_reg;
    grant_t                       grant;

    assign push_entry = {s_address, s_byteenable, s_writedata};

    ocram_wbuf_bridge_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (wr_acc),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_entry (head_entry),
        .ent_valid  (ent_valid),
        .ent_addr   (ent_addr)
    );

    // A read hits if any live entry carries the same word address (lanes ignored)
    for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_match
        assign addr_match[gi] = ent_valid[gi] &&
                                (ent_addr[gi*ADDR_W +: ADDR_W] == s_address);
    end
    assign hazard = |addr_match;

    // ready_reg is cleared asynchronously, so requests stall the moment reset asserts
    assign wr_acc        = ready_reg && s_write && !fifo_full;
    assign rd_acc        = ready_reg && s_read && !fifo_full && !hazard;
    assign s_waitrequest = !ready_reg || fifo_full || (s_read && hazard);
    assign fifo_pop      = (grant == GNT_DRAIN);

    // Slave becomes ready on the first clock edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_reg <= 1'b0;
        else          ready_reg <= 1'b1;
    end

    // RAM port arbitration: a full buffer must drain, otherwise reads go first
    always_comb begin
        grant = GNT_IDLE;
        if (fifo_full)        grant = GNT_DRAIN;
        else if (rd_acc)      grant = GNT_READ;
        else if (!fifo_empty) grant = GNT_DRAIN;
    end

    // Drive the RAM port from the granted source; idle cycles drive zeros
    always_comb begin
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        case (grant)
            GNT_READ: begin
                ram_chipselect = 1'b1;
                ram_address    = s_address;
                ram_byteenable = '1;
            end
            GNT_DRAIN: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_address    = head_entry[ADDR_LSB +: ADDR_W];
                ram_byteenable = head_entry[BE_LSB +: BE_W];
                ram_writedata  = head_entry[ENT_DATA_LSB +: DATA_W];
            end
            default: ;
        endcase
    end

    assign ram_clken  = 1'b1;
    assign s_readdata = ram_readdata;

    // readdatavalid follows an accepted read by exactly one cycle, matching RAM latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdv_reg <= 1'b0;
        else          rdv_reg <= rd_acc;
    end
    assign s_readdatavalid = rdv_reg;

`ifdef OCRAM_WBUF_STATS_EN
    logic [2:0] stat_evt;
    assign stat_evt = {s_read && hazard && ready_reg, wr_acc, rd_acc};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [31:0] cnt_reg;
        // Saturating event counter with synchronous clear
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                cnt_reg <= '0;
            else if (stats_clr)
                cnt_reg <= '0;
            else if (stat_evt[gi] && (cnt_reg != 32'hFFFF_FFFF))
                cnt_reg <= cnt_reg + 32'd1;
        end
    end

    assign stat_reads         = g_stat[0].cnt_reg;
    assign stat_writes        = g_stat[1].cnt_reg;
    assign stat_hazard_stalls = g_stat[2].cnt_reg;
`else
    logic unused_stats_clr;
    assign unused_stats_clr   = stats_clr;
    assign stat_reads         = '0;
    assign stat_writes        = '0;
    assign stat_hazard_stalls = '0;
`endif

endmodule

// File: tb/tb_ocram_wbuf_bridge.sv
// tb_ocram_wbuf_bridge: directed + random stimulus against a behavioural model.
// The model tracks the architectural memory image (latest accepted write per word),
// the list of writes accepted but not yet seen on the RAM port, and the expected
// read returns. A bench RAM with 1-cycle read latency sits on the RAM port.
module tb_ocram_wbuf_bridge;
    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] s_address = '0;
    logic          s_read = 1'b0;
    logic          s_write = 1'b0;
    logic [BW-1:0] s_byteenable = '0;
    logic [DW-1:0] s_writedata = '0;
    logic          stats_clr = 1'b0;
    logic          s_waitrequest;
    logic [DW-1:0] s_readdata;
    logic          s_readdatavalid;
    logic [AW-1:0] ram_address;
    logic [BW-1:0] ram_byteenable;
    logic          ram_chipselect;
    logic          ram_write;
    logic [DW-1:0] ram_writedata;
    logic          ram_clken;
    logic [DW-1:0] ram_readdata;
    logic [31:0]   stat_reads;
    logic [31:0]   stat_writes;
    logic [31:0]   stat_hazard_stalls;

    always #5 clk = ~clk;

    ocram_wbuf_bridge #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .s_address          (s_address),
        .s_read             (s_read),
        .s_write            (s_write),
        .s_byteenable       (s_byteenable),
        .s_writedata        (s_writedata),
        .s_waitrequest      (s_waitrequest),
        .s_readdata         (s_readdata),
        .s_readdatavalid    (s_readdatavalid),
        .ram_address        (ram_address),
        .ram_byteenable     (ram_byteenable),
        .ram_chipselect     (ram_chipselect),
        .ram_write          (ram_write),
        .ram_writedata      (ram_writedata),
        .ram_clken          (ram_clken),
        .ram_readdata       (ram_readdata),
        .stats_clr          (stats_clr),
        .stat_reads         (stat_reads),
        .stat_writes        (stat_writes),
        .stat_hazard_stalls (stat_hazard_stalls)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Bench RAM: 1-cycle read latency, byte-lane writes, preloaded with addr+0x100
    logic [DW-1:0] ram_mem [1 << AW];
    logic [DW-1:0] ram_q;
    int            ram_wr_count;
    assign ram_readdata = ram_q;
    initial begin
        ram_wr_count = 0;
        ram_q = '0;
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = DW'(i + 'h100);
        forever begin
            @(posedge clk);
            if (ram_chipselect) begin
                if (ram_write) begin
                    ram_mem[ram_address] <= merge(ram_mem[ram_address], ram_writedata, ram_byteenable);
                    ram_wr_count <= ram_wr_count + 1;
                end else begin
                    ram_q <= ram_mem[ram_address];
                end
            end
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           pend [$];
    logic [DW-1:0] arch [1 << AW];
    logic          m_ready = 1'b0;
    logic          prev_rd = 1'b0;
    logic [DW-1:0] prev_rd_exp = '0;
    logic          prev_lit_v = 1'b0;
    logic [DW-1:0] prev_lit = '0;
    int            m_reads = 0;
    int            m_writes = 0;
    int            m_stalls = 0;

    // values sampled by the compare process, consumed at the following edge
    logic          acc_rd = 1'b0;
    logic          acc_wr = 1'b0;
    logic          drain_e = 1'b0;
    logic          hz_cyc = 1'b0;
    logic [AW-1:0] cap_addr = '0;
    logic [BW-1:0] cap_be = '0;
    logic [DW-1:0] cap_data = '0;
    logic          cap_lit_v = 1'b0;
    logic [DW-1:0] cap_lit = '0;

    // literal expectation attached to the request currently driven
    logic          lit_v = 1'b0;
    logic [DW-1:0] lit_val = '0;

    function automatic bit pend_hit(input logic [AW-1:0] a);
        foreach (pend[i]) if (pend[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit drain_due(input bit rd_taken);
        return (pend.size() == DEPTH) || (!rd_taken && pend.size() != 0);
    endfunction

    // Compare process: DUT outputs against the model, once per cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_waitrequest", s_waitrequest, 1);
            chk("rst_readdatavalid", s_readdatavalid, 0);
            chk("rst_chipselect", ram_chipselect, 0);
            chk("rst_ram_write", ram_write, 0);
            acc_rd  <= 1'b0;
            acc_wr  <= 1'b0;
            drain_e <= 1'b0;
            hz_cyc  <= 1'b0;
        end else begin
            chk("waitrequest", s_waitrequest,
                !m_ready || pend.size() == DEPTH || (s_read && pend_hit(s_address)));
            chk("ram_clken", ram_clken, 1);
            if (drain_due(s_read && !s_waitrequest)) begin
                chk("drain_cs", ram_chipselect, 1);
                chk("drain_we", ram_write, 1);
                chk("drain_addr", ram_address, pend[0].a);
                chk("drain_be", ram_byteenable, pend[0].be);
                chk("drain_data", ram_writedata, pend[0].d);
            end else if (s_read && !s_waitrequest) begin
                chk("read_cs", ram_chipselect, 1);
                chk("read_we", ram_write, 0);
                chk("read_addr", ram_address, s_address);
            end else begin
                chk("idle_cs", ram_chipselect, 0);
            end
            chk("readdatavalid", s_readdatavalid, prev_rd);
            if (prev_rd && s_readdatavalid) begin
                chk("readdata", s_readdata, prev_rd_exp);
                if (prev_lit_v) chk("readdata_literal", s_readdata, prev_lit);
            end
            chk("stat_reads", stat_reads, m_reads);
            chk("stat_writes", stat_writes, m_writes);
            chk("stat_hazard_stalls", stat_hazard_stalls, m_stalls);
            acc_rd    <= s_read && !s_waitrequest;
            acc_wr    <= s_write && !s_waitrequest;
            drain_e   <= drain_due(s_read && !s_waitrequest);
            hz_cyc    <= s_read && m_ready && pend_hit(s_address);
            cap_addr  <= s_address;
            cap_be    <= s_byteenable;
            cap_data  <= s_writedata;
            cap_lit_v <= lit_v;
            cap_lit   <= lit_val;
        end
    end

    // Model update at each clock edge
    always @(posedge clk) begin
        m_ready <= reset_n;
        if (!reset_n) begin
            pend.delete();
            prev_rd    <= 1'b0;
            prev_lit_v <= 1'b0;
            m_reads    <= 0;
            m_writes   <= 0;
            m_stalls   <= 0;
            // queued writes are lost, so the architectural image is whatever the RAM holds
            for (int i = 0; i < (1 << AW); i++) arch[i] <= ram_mem[i];
        end else begin
            if (drain_e && pend.size() != 0) void'(pend.pop_front());
            if (acc_wr) begin
                pend.push_back(wr_t'{cap_addr, cap_be, cap_data});
                arch[cap_addr] <= merge(arch[cap_addr], cap_data, cap_be);
            end
            prev_rd     <= acc_rd;
            prev_rd_exp <= arch[cap_addr];
            prev_lit_v  <= acc_rd && cap_lit_v;
            prev_lit    <= cap_lit;
`ifdef OCRAM_WBUF_STATS_EN
            if (stats_clr) begin
                m_reads  <= 0;
                m_writes <= 0;
                m_stalls <= 0;
            end else begin
                m_reads  <= m_reads + int'(acc_rd);
                m_writes <= m_writes + int'(acc_wr);
                m_stalls <= m_stalls + int'(hz_cyc);
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic xfer(input bit rd, input logic [AW-1:0] a, input logic [BW-1:0] be,
                        input logic [DW-1:0] d, input bit lv, input logic [DW-1:0] lval,
                        output int n);
        s_read       = rd;
        s_write      = !rd;
        s_address    = a;
        s_byteenable = be;
        s_writedata  = d;
        lit_v        = lv;
        lit_val      = lval;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(acc_rd || acc_wr) && n < 64);
        checks++;
        if (!(acc_rd || acc_wr)) begin
            errors++;
            $display("FAIL accept_timeout: addr %0h not accepted within %0d cycles", a, n);
        end
        #1;
        s_read  = 1'b0;
        s_write = 1'b0;
        lit_v   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int cyc;
    int snap;
    int sel;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(1);

        // 1: back-to-back reads, one per cycle, data addr+0x100
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, AW'(i), '1, '0, 1'b1, DW'(32'h100 + i), cyc);
            chk("b2b_read_cycles", cyc, 1);
        end
        idle(2);

        // 2: write burst with no reads; RAM must receive all five in order
        for (int i = 0; i < 5; i++) xfer(1'b0, AW'(16 + i), '1, DW'(32'h1000_00A0 + i), 1'b0, '0, cyc);
        idle(6);
        for (int i = 0; i < 5; i++) chk("burst_ram_content", ram_mem[16 + i], DW'(32'h1000_00A0 + i));

        // 3: partial write then same-address read must stall until the drain
        xfer(1'b0, AW'('h20), 4'b0011, 32'hDEAD_BEEF, 1'b0, '0, cyc);
        xfer(1'b1, AW'('h20), '1, '0, 1'b1, 32'h0000_BEEF, cyc);
        chk("hazard_read_cycles", cyc, 2);
        idle(2);

        // 4: queued writes do not delay a read to another address
        for (int i = 0; i < 3; i++) xfer(1'b0, AW'('h30 + i), '1, DW'(32'h3000_0000 + i), 1'b0, '0, cyc);
        xfer(1'b1, AW'('h40), '1, '0, 1'b1, 32'h0000_0140, cyc);
        chk("bypass_read_cycles", cyc, 1);
        idle(4);

        // 5: reset with a write still queued and a read presented during reset
        xfer(1'b0, AW'('h50), '1, 32'h5555_0050, 1'b0, '0, cyc);
        xfer(1'b0, AW'('h51), '1, 32'h5555_0051, 1'b0, '0, cyc);
        reset_n   = 1'b0;
        s_read    = 1'b1;
        s_address = AW'(7);
        snap      = ram_wr_count;
        repeat (3) @(posedge clk);
        #1;
        s_read  = 1'b0;
        reset_n = 1'b1;
        idle(3);
        chk("reset_no_ram_write", ram_wr_count, snap);
        chk("reset_discarded_write", ram_mem['h51], 32'h0000_0151);
        chk("pre_reset_write", ram_mem['h50], 32'h5555_0050);

        // random mix over a small address window so hazards are common
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 2) idle(1);
            else if (sel < 6)
                xfer(1'b1, AW'($urandom_range(0, 7)), '1, '0, 1'b0, '0, cyc);
            else
                xfer(1'b0, AW'($urandom_range(0, 7)), BW'($urandom), DW'($urandom), 1'b0, '0, cyc);
        end
        idle(8);
        for (int a = 0; a < 8; a++) chk("final_ram_vs_model", ram_mem[a], arch[a]);

        // statistics clear pulse: counters read zero on the following cycle
        stats_clr = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        @(negedge clk);
        chk("stats_clr_reads", stat_reads, 0);
        chk("stats_clr_writes", stat_writes, 0);
        chk("stats_clr_stalls", stat_hazard_stalls, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
